rr_arbiter: RTL and testbench
=============================

Name: rr_arbiter

Overview:
Parametrised N-requester bus arbiter. It succeeds the fixed 4-way priority arbiter.
- Adds rotating (round-robin) fairness, grant lock while the owner keeps requesting, and a bounded hold time.
- Grant and bus index are registered.
- Sits between requesting masters and the shared bus mux; bus drives the mux select.

Parameters:
N_REQ, 4, number of requesters (2..16)
IDW, $clog2(N_REQ), width of bus index (derived, not overridden)
MAX_HOLD, 8, max consecutive grant cycles while others wait; 0 = unlimited

Ports:
clk  input  1  clock, all state on posedge
reset  input  1  synchronous, active-low reset
req  input  N_REQ  request vector, bit i = requester i
grant  output  N_REQ  registered one-hot grant, all-zero when idle
bus  output  IDW  index of current/last grantee
valid  output  1  high when grant is non-zero

Behaviour:
- Reset: reset==0 at a posedge clears everything:
  - grant=0, bus=0, valid=0, hold_cnt=0, state=IDLE.
  - Rotation pointer last=N_REQ-1, so the first search starts at index 0.
  - Reset has priority over all other events, including mid-grant.
- States:
  - IDLE: no owner.
  - BUSY: owner = bus, grant[bus]=1.
- IDLE:
  - req==0 -> stay IDLE; bus holds last value, valid=0.
  - req!=0 -> pick winner W = first set bit searching last+1, last+2, ... modulo N_REQ.
  - Next edge: grant=onehot(W), bus=W, valid=1, last=W, hold_cnt=1, state BUSY. Latency is 1 edge.
- BUSY, owner request dropped (req[bus]==0):
  - Others pending -> re-arbitrate from bus+1 in the same edge; no bubble cycle.
  - No others pending -> IDLE with grant=0, valid=0, bus retained.
- BUSY, owner still requesting:
  - Keep the grant while MAX_HOLD==0, or hold_cnt<MAX_HOLD, or no other req bit is set.
  - Otherwise preempt: re-arbitrate from bus+1, excluding the owner; hold_cnt=1.
- hold_cnt:
  - Increments each kept cycle.
  - Saturates at MAX_HOLD when the owner is sole requester; no wrap.
- Wrap-around: search index arithmetic is modulo N_REQ. Non-power-of-2 N_REQ never yields an index >= N_REQ.
- Simultaneous drop of the owner and rise of others: treated as the owner-dropped case.
- Invariants: grant is always zero or one-hot; valid == |grant; bus == encode(grant) whenever valid.

Optional Feature:
Macro ARB_FIXED_PRIO_EN.
- Defined: rotation pointer removed.
  - Winner is always the highest-index set req bit, matching the legacy priority order.
  - On preemption, winner is the highest-index set bit excluding the owner.
  - Lock and MAX_HOLD still apply.
- Undefined: round-robin as above.
- Port list identical in both builds.

Decomposition:
- Package arb_pkg:
  - function clog2-safe IDW helper
  - state typedef {IDLE, BUSY}
  - localparam for the reset pointer value
- Sub-module rr_pick (combinational):
  - Inputs: req, start index, exclude mask.
  - Outputs: winner index and found flag.
  - Built from a double-width rotate and priority-encode.
  - Fixed-priority variant selected by the macro inside rr_pick.
- Top level holds the state, hold counter, pointer and output registers.

Test Plan (N_REQ=4, MAX_HOLD=4 unless noted):
1. reset=0 for 2 edges with req=1111 -> grant=0000, bus=00, valid=0. First edge after reset=1 -> grant=0001, bus=00, valid=1.
2. req=0001 for 3 edges, then req=0010 -> grant=0001 for 3 edges, then 0010, bus=01 on the next edge, no idle cycle. Then req=0000 -> grant=0000, valid=0, bus stays 01.
3. req=1111 held 17 edges -> grant sequence 0001x4, 0010x4, 0100x4, 1000x4, 0001; bus tracks 0,1,2,3,0.
4. req=0100 alone for 10 edges -> grant=0100 all 10 edges, no preemption, hold_cnt saturates at 4. Then req=0101 -> grant moves to 0001 on the next edge.
5. Grant at 0010 with req=0110, then reset=0 for 1 edge -> grant=0000, valid=0, bus=00. Release with req=0110 -> grant=0010, since the pointer has restarted at 0.
6. ARB_FIXED_PRIO_EN, MAX_HOLD=0:
   - req=0111 -> grant=0100.
   - req=1111 while 0100 is still requesting -> grant stays 0100 (lock).
   - req=1011 -> grant=1000.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
// Build option ARB_FIXED_PRIO_EN (see rr_pick) selects legacy highest-index-wins priority.
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Pointer resets to N_REQ - PTR_RESET_BACKOFF so the first search begins at index 0.
    localparam int unsigned PTR_RESET_BACKOFF = 1;

    function automatic int calc_idw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner search: first set bit of (req & ~excl) starting at 'start', modulo N_REQ.
// With ARB_FIXED_PRIO_EN defined the highest-index set bit wins and 'start' is ignored.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDW   = calc_idw(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   start,
    input  logic [N_REQ-1:0] excl,
    output logic [IDW-1:0]   winner,
    output logic             found
);

    logic [N_REQ-1:0] masked;

    assign masked = req & ~excl;
    assign found  = |masked;

`ifdef ARB_FIXED_PRIO_EN
    logic unused_start;

    assign unused_start = ^start;

    always_comb begin
        winner = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (masked[i]) winner = IDW'(i);
        end
    end
`else
    logic [N_REQ-1:0] rot;
    logic [IDW-1:0]   offset;
    logic [IDW:0]     sum;

    // Doubling the vector turns the rotate into a plain right shift.
    assign rot = N_REQ'({masked, masked} >> start);

    always_comb begin
        offset = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) offset = IDW'(i);
        end
    end

    assign sum    = {1'b0, start} + {1'b0, offset};
    assign winner = (sum >= (IDW+1)'(N_REQ)) ? IDW'(sum - (IDW+1)'(N_REQ)) : sum[IDW-1:0];
`endif

endmodule

// File: rtl/rr_arbiter.sv
// N-requester bus arbiter: round-robin fairness, grant lock and bounded hold, registered outputs.
// ARB_FIXED_PRIO_EN drops the rotation pointer in favour of highest-index-wins priority.
//
//   state | meaning
//   IDLE  | no owner; grant=0, bus keeps last grantee
//   BUSY  | owner = bus, grant[bus]=1, hold_cnt counts consecutive owned cycles
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int    N_REQ    = 4,
    parameter int    MAX_HOLD = 8,
    localparam int   IDW      = calc_idw(N_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   bus,
    output logic             valid
);

    localparam int               HCW       = calc_idw(MAX_HOLD + 1);
    localparam bit               UNLIMITED = (MAX_HOLD == 0);
    localparam logic [HCW-1:0]   HOLD_LIM  = HCW'((MAX_HOLD == 0) ? 1 : MAX_HOLD);
    localparam logic [N_REQ-1:0] ONE_HOT0  = N_REQ'(1);

    arb_state_t       state;
    logic [HCW-1:0]   hold_cnt;
    logic [IDW-1:0]   start;
    logic [IDW-1:0]   winner;
    logic [N_REQ-1:0] excl;
    logic             found;
    logic             keep;

`ifdef ARB_FIXED_PRIO_EN
    assign start = '0;
`else
    localparam logic [IDW-1:0] LAST_RST = IDW'(N_REQ - PTR_RESET_BACKOFF);
    localparam logic [IDW-1:0] LAST_IDX = IDW'(N_REQ - 1);

    logic [IDW-1:0] last;

    // While BUSY, last == bus, so one search origin serves idle, drop and preempt cases.
    assign start = (last == LAST_IDX) ? '0 : last + 1'b1;
`endif

    assign excl = (state == BUSY) ? (ONE_HOT0 << bus) : '0;
    assign keep = UNLIMITED || (hold_cnt < HOLD_LIM) || !found;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .req    (req),
        .start  (start),
        .excl   (excl),
        .winner (winner),
        .found  (found)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            grant    <= '0;
            bus      <= '0;
            valid    <= 1'b0;
            hold_cnt <= '0;
`ifndef ARB_FIXED_PRIO_EN
            last     <= LAST_RST;
`endif
        end else if ((state == BUSY) && req[bus] && keep) begin
            if (hold_cnt < HOLD_LIM) hold_cnt <= hold_cnt + 1'b1;
        end else if (found) begin
            state    <= BUSY;
            grant    <= ONE_HOT0 << winner;
            bus      <= winner;
            valid    <= 1'b1;
            hold_cnt <= HCW'(1);
`ifndef ARB_FIXED_PRIO_EN
            last     <= winner;
`endif
        end else begin
            state <= IDLE;
            grant <= '0;
            valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter: directed literal checks plus randomized traffic vs. a queue-free behavioural model.
module tb_rr_arbiter;

    localparam int N = 4;
`ifdef ARB_FIXED_PRIO_EN
    localparam int MH = 0;
`else
    localparam int MH = 4;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] grant;
    logic [1:0]   bus;
    logic         valid;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // model state: owner = -1 when idle
    int m_owner = -1;
    int m_bus   = 0;
    int m_hold  = 0;
    int m_last  = N - 1;

    rr_arbiter #(.N_REQ(N), .MAX_HOLD(MH)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .grant (grant),
        .bus   (bus),
        .valid (valid)
    );

    always #5 clk = ~clk;

    function automatic int pick(input int from, input int excl_idx, input logic [N-1:0] r);
`ifdef ARB_FIXED_PRIO_EN
        for (int idx = N - 1; idx >= 0; idx--)
            if (r[idx] && idx != excl_idx) return idx;
`else
        for (int off = 0; off < N; off++) begin
            int idx;
            idx = (from + off) % N;
            if (r[idx] && idx != excl_idx) return idx;
        end
`endif
        return -1;
    endfunction

    function automatic logic [N-1:0] m_grant();
        return (m_owner < 0) ? '0 : (N'(1) << m_owner);
    endfunction

    always @(posedge clk) begin
        int w;
        if (!reset) begin
            m_owner = -1; m_bus = 0; m_hold = 0; m_last = N - 1;
        end else begin
            w = -2;
            if (m_owner < 0) begin
                w = pick(m_last + 1, -1, req);
            end else if (!req[m_owner]) begin
                w = pick(m_owner + 1, -1, req);
            end else if (MH == 0 || m_hold < MH || (req & ~(N'(1) << m_owner)) == '0) begin
                if (MH != 0 && m_hold < MH) m_hold = m_hold + 1;
            end else begin
                w = pick(m_owner + 1, m_owner, req);
            end
            if (w >= 0) begin
                m_owner = w; m_bus = w; m_last = w; m_hold = 1;
            end else if (w == -1) begin
                m_owner = -1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            total++;
            if (grant !== m_grant() || valid !== (m_owner >= 0) || bus !== 2'(m_bus)) begin
                bad++;
                $display("FAIL model t=%0t req=%b grant=%b/%b bus=%0d/%0d valid=%b/%b (actual/required)",
                         $time, req, grant, m_grant(), bus, m_bus, valid, (m_owner >= 0));
            end
            total++;
            if (valid !== (|grant) || (grant & (grant - 1'b1)) != '0) begin
                bad++;
                $display("FAIL invariant t=%0t grant=%b valid=%b", $time, grant, valid);
            end
        end
    end

    task automatic cyc(input logic [N-1:0] r, input logic rst);
        req = r;
        reset = rst;
        @(negedge clk);
    endtask

    task automatic expect_lit(input string name, input logic [N-1:0] g, input logic [1:0] b, input logic v);
        total++;
        if (grant !== g || bus !== b || valid !== v) begin
            bad++;
            $display("FAIL %s grant=%b bus=%0d valid=%b required grant=%b bus=%0d valid=%b",
                     name, grant, bus, valid, g, b, v);
        end
    endtask

    initial begin
        req = 4'b1111;
        reset = 1'b0;
        @(negedge clk);
        cyc(4'b1111, 1'b0);
        chk_en = 1'b1;
        expect_lit("reset_hold", 4'b0000, 2'd0, 1'b0);
`ifndef ARB_FIXED_PRIO_EN
        cyc(4'b1111, 1'b1);
        expect_lit("first_grant", 4'b0001, 2'd0, 1'b1);
        // owner keeps alone, then hands off without a bubble
        for (int i = 0; i < 3; i++) begin
            cyc(4'b0001, 1'b1);
            expect_lit("lock_owner0", 4'b0001, 2'd0, 1'b1);
        end
        cyc(4'b0010, 1'b1);
        expect_lit("handoff_no_bubble", 4'b0010, 2'd1, 1'b1);
        cyc(4'b0000, 1'b1);
        expect_lit("idle_bus_kept", 4'b0000, 2'd1, 1'b0);
        // full contention rotates every MAX_HOLD cycles
        cyc(4'b1111, 1'b0);
        for (int i = 0; i < 17; i++) begin
            cyc(4'b1111, 1'b1);
            expect_lit("rotate_1111", 4'b0001 << ((i / 4) % 4), 2'((i / 4) % 4), 1'b1);
        end
        for (int i = 0; i < 10; i++) begin
            cyc(4'b0100, 1'b1);
            expect_lit("sole_no_preempt", 4'b0100, 2'd2, 1'b1);
        end
        cyc(4'b0101, 1'b1);
        expect_lit("preempt_after_sat", 4'b0001, 2'd0, 1'b1);
        cyc(4'b0110, 1'b1);
        expect_lit("grant_0010", 4'b0010, 2'd1, 1'b1);
        cyc(4'b0110, 1'b0);
        expect_lit("midgrant_reset", 4'b0000, 2'd0, 1'b0);
        cyc(4'b0110, 1'b1);
        expect_lit("ptr_restart", 4'b0010, 2'd1, 1'b1);
`else
        cyc(4'b0111, 1'b1);
        expect_lit("fixed_highest", 4'b0100, 2'd2, 1'b1);
        cyc(4'b1111, 1'b1);
        expect_lit("fixed_lock", 4'b0100, 2'd2, 1'b1);
        cyc(4'b1011, 1'b1);
        expect_lit("fixed_drop", 4'b1000, 2'd3, 1'b1);
`endif
        for (int i = 0; i < 800; i++) begin
            logic [N-1:0] r;
            r = (($urandom_range(0, 3) == 0) ? req : 4'($urandom_range(0, 15)));
            cyc(r, ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1);
        end
        cyc(4'b0000, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
